// File: rtl/lms_adapt_ctrl_if.sv
// lms_adapt_ctrl_if: control/status bundle between the LMS adaptation
// sequencer and its environment (filter error/overflow in, step size out).
interface lms_adapt_ctrl_if #(
    parameter int WIDTH = 16
);
    logic                    i_start;
    logic                    i_freeze;
    logic                    i_valid;
    logic signed [WIDTH-1:0] i_error;
    logic                    i_ovr;
    logic        [WIDTH-1:0] i_mu_init;
    logic        [WIDTH-1:0] i_mu_floor;
    logic        [WIDTH-1:0] i_conv_thresh;
    logic        [WIDTH-1:0] o_step_size;
    logic                    o_adapt_en;
    logic                    o_weights_clr;
    logic        [2:0]       o_state;
    logic                    o_converged;
    logic                    o_fault;
    logic        [WIDTH-1:0] o_err_avg;

    modport master (
        output i_start, i_freeze, i_valid, i_error, i_ovr,
               i_mu_init, i_mu_floor, i_conv_thresh,
        input  o_step_size, o_adapt_en, o_weights_clr, o_state,
               o_converged, o_fault, o_err_avg
    );

    modport slave (
        input  i_start, i_freeze, i_valid, i_error, i_ovr,
               i_mu_init, i_mu_floor, i_conv_thresh,
        output o_step_size, o_adapt_en, o_weights_clr, o_state,
               o_converged, o_fault, o_err_avg
    );
endinterface

// File: rtl/lms_adapt_ctrl.sv
// lms_adapt_ctrl: sequences LMS adaptation (clear -> train with decaying
// step -> track at floor step), tracks a leaky average of |error| for
// convergence detection, and latches a fault on filter overflow.
// Optional: define LMS_ADAPT_CTRL_RETRAIN_EN to fall back from TRACK to
// TRAIN when the averaged error stays at/above twice the threshold.
module lms_adapt_ctrl #(
    parameter int WIDTH        = 16,
    parameter int DECAY_PERIOD = 64,
    parameter int AVG_SHIFT    = 4,
    parameter int CONV_HOLD    = 32,
    parameter int CLR_CYCLES   = 4
) (
    input  logic            clk,
    input  logic            rstn,
    lms_adapt_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_TRAIN  = 3'd2,
        S_TRACK  = 3'd3,
        S_FREEZE = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam int DW = $clog2(DECAY_PERIOD + 1);
    localparam int HW = $clog2(CONV_HOLD + 1);
    localparam int CW = $clog2(CLR_CYCLES + 1);
    localparam logic [DW-1:0]    DEC_LAST  = DW'(DECAY_PERIOD - 1);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(CONV_HOLD - 1);
    localparam logic [CW-1:0]    CLR_LAST  = CW'(CLR_CYCLES - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] POS_MAX   = {1'b0, {(WIDTH-1){1'b1}}};

    state_t            r_state, r_ret, w_next;
    logic [WIDTH-1:0]  r_step, r_avg;
    logic [DW-1:0]     r_dcnt;
    logic [HW-1:0]     r_hold;
    logic [CW-1:0]     r_clr_cnt;
    logic              r_conv;

    logic [WIDTH-1:0]  w_abs, w_avg_new, w_half, w_decayed, w_init_step;
    logic signed [WIDTH:0] w_diff, w_avg_sum;
    logic              w_adapting, w_fault_ev, w_upd, w_below, w_conv;
`ifdef LMS_ADAPT_CTRL_RETRAIN_EN
    logic [WIDTH-1:0]  w_retrain_step;
    logic              w_high, w_retrain;
`endif

    // Datapath helpers: saturated |error|, leaky-average update, step candidates
    always_comb begin
        w_abs = bus.i_error;
        if (bus.i_error == MOST_NEG) w_abs = POS_MAX;
        else if (bus.i_error[WIDTH-1]) w_abs = -bus.i_error;
        w_diff    = $signed({1'b0, w_abs}) - $signed({1'b0, r_avg});
        w_avg_sum = $signed({1'b0, r_avg}) + (w_diff >>> AVG_SHIFT);
        w_avg_new = w_avg_sum[WIDTH] ? '0 : w_avg_sum[WIDTH-1:0];
        w_half      = r_step >> 1;
        w_decayed   = (w_half > bus.i_mu_floor) ? w_half : bus.i_mu_floor;
        w_init_step = (bus.i_mu_init <= bus.i_mu_floor) ? bus.i_mu_floor : bus.i_mu_init;
        w_adapting = (r_state == S_TRAIN) || (r_state == S_TRACK);
        w_fault_ev = w_adapting && bus.i_valid && bus.i_ovr;
        // a sample only counts when the state is not about to change for a higher-priority event
        w_upd      = w_adapting && bus.i_valid && !bus.i_ovr && !bus.i_start && !bus.i_freeze;
        w_below    = r_avg < bus.i_conv_thresh;
        w_conv     = (r_state == S_TRAIN) && w_upd && w_below && (r_hold == HOLD_LAST);
`ifdef LMS_ADAPT_CTRL_RETRAIN_EN
        w_high         = {1'b0, r_avg} >= {bus.i_conv_thresh, 1'b0};
        w_retrain      = (r_state == S_TRACK) && w_upd && w_high && (r_hold == HOLD_LAST);
        w_retrain_step = ((bus.i_mu_init >> 1) > bus.i_mu_floor) ? (bus.i_mu_init >> 1)
                                                                 : bus.i_mu_floor;
`endif
    end

    // Next-state selection in priority order: fault, start, freeze, local
    always_comb begin
        w_next = r_state;
        if (w_fault_ev) begin
            w_next = S_FAULT;
        end else if (bus.i_start && (r_state != S_CLEAR)) begin
            w_next = S_CLEAR;
        end else if (bus.i_freeze && w_adapting) begin
            w_next = S_FREEZE;
        end else begin
            case (r_state)
                S_CLEAR:  if (r_clr_cnt == CLR_LAST) w_next = S_TRAIN;
                S_TRAIN:  if (w_conv) w_next = S_TRACK;
                S_TRACK: begin
`ifdef LMS_ADAPT_CTRL_RETRAIN_EN
                    if (w_retrain) w_next = S_TRAIN;
`else
                    w_next = S_TRACK;
`endif
                end
                S_FREEZE: if (!bus.i_freeze) w_next = r_ret;
                default:  w_next = r_state;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Counters, average, step size and sticky converged flag
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ret     <= S_IDLE;
            r_step    <= '0;
            r_avg     <= '0;
            r_dcnt    <= '0;
            r_hold    <= '0;
            r_clr_cnt <= '0;
            r_conv    <= 1'b0;
        end else begin
            r_clr_cnt <= (r_state == S_CLEAR) ? r_clr_cnt + 1'b1 : '0;
            if ((w_next == S_FREEZE) && (r_state != S_FREEZE)) r_ret <= r_state;
            case (r_state)
                S_CLEAR: begin
                    r_avg  <= '0;
                    r_dcnt <= '0;
                    r_hold <= '0;
                    r_conv <= 1'b0;
                    if (w_next == S_TRAIN) r_step <= w_init_step;
                end
                S_TRAIN: begin
                    if (w_upd) begin
                        r_avg <= w_avg_new;
                        if (r_dcnt == DEC_LAST) begin
                            r_dcnt <= '0;
                            r_step <= w_decayed;
                        end else begin
                            r_dcnt <= r_dcnt + 1'b1;
                        end
                        r_hold <= w_below ? r_hold + 1'b1 : '0;
                    end
                    if (w_conv) begin
                        r_conv <= 1'b1;
                        r_step <= bus.i_mu_floor;
                        r_hold <= '0;
                    end
                end
                S_TRACK: begin
                    r_step <= bus.i_mu_floor;
                    if (w_upd) r_avg <= w_avg_new;
`ifdef LMS_ADAPT_CTRL_RETRAIN_EN
                    if (w_upd) r_hold <= w_high ? r_hold + 1'b1 : '0;
                    if (w_retrain) begin
                        r_step <= w_retrain_step;
                        r_conv <= 1'b0;
                        r_hold <= '0;
                        r_dcnt <= '0;
                    end
`else
                    r_hold <= '0;
`endif
                end
                default: ;
            endcase
            if (w_fault_ev) r_conv <= 1'b0;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        bus.o_state       = r_state;
        bus.o_adapt_en    = w_adapting;
        bus.o_weights_clr = (r_state == S_CLEAR);
        bus.o_fault       = (r_state == S_FAULT);
        bus.o_converged   = r_conv;
        bus.o_err_avg     = r_avg;
        bus.o_step_size   = w_adapting ? r_step : '0;
    end
endmodule

// File: tb/tb_lms_adapt_ctrl.sv
// tb_lms_adapt_ctrl: directed vector table plus hand-written multi-cycle
// sequences for decay, convergence, freeze/resume, fault and floor clamping.
module tb_lms_adapt_ctrl;
    localparam int WIDTH = 16;

    typedef struct {
        logic [3:0]  ctl;   // {start, freeze, valid, ovr}
        logic [15:0] err;
        logic [2:0]  st;
        logic [15:0] step;
        logic [3:0]  flg;   // {adapt_en, weights_clr, converged, fault}
        logic [15:0] avg;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] m_avg;
    vec_t        tbl [20];

    always #5 clk = ~clk;

    lms_adapt_ctrl_if #(.WIDTH(WIDTH)) bus ();

    lms_adapt_ctrl #(
        .WIDTH(WIDTH), .DECAY_PERIOD(64), .AVG_SHIFT(4), .CONV_HOLD(32), .CLR_CYCLES(4)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bus)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ctl, input logic [15:0] err);
        bus.i_start  = ctl[3];
        bus.i_freeze = ctl[2];
        bus.i_valid  = ctl[1];
        bus.i_ovr    = ctl[0];
        bus.i_error  = err;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] st, input logic [15:0] step,
                           input logic [3:0] flg);
        chk({tag, ".state"}, 32'(bus.o_state), 32'(st));
        chk({tag, ".step"}, 32'(bus.o_step_size), 32'(step));
        chk({tag, ".flags"}, 32'({bus.o_adapt_en, bus.o_weights_clr, bus.o_converged, bus.o_fault}),
            32'(flg));
    endtask

    // Reference leaky average with saturated |e|, in plain integer arithmetic
    function automatic logic [15:0] avg_upd(input logic [15:0] avg, input logic [15:0] e);
        int mag;
        int r;
        mag = int'($signed(e));
        if (mag < 0) mag = -mag;
        if (mag > 32767) mag = 32767;
        r = int'(avg);
        r = r + ((mag - r) >>> 4);
        return r[15:0];
    endfunction

    // Expected step after k valid samples in TRAIN from a fresh start
    function automatic logic [15:0] exp_step(input logic [15:0] mu, input logic [15:0] fl, input int k);
        logic [15:0] e;
        e = (mu <= fl) ? fl : mu;
        for (int j = 0; j < k / 64; j++) begin
            e = e >> 1;
            if (e < fl) e = fl;
        end
        return e;
    endfunction

    task automatic restart(input string tag, input logic [15:0] step);
        drive(4'b1000, 16'd0);
        cyc();
        drive(4'b0000, 16'd0);
        repeat (3) cyc();
        chk_out({tag, ".clear"}, 3'd1, 16'h0000, 4'b0100);
        cyc();
        chk_out({tag, ".train"}, 3'd2, step, 4'b1000);
        m_avg = 16'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'b1000, 16'd0,    3'd1, 16'h0000, 4'b0100, 16'd0};
        tbl[1]  = '{4'b1000, 16'd0,    3'd1, 16'h0000, 4'b0100, 16'd0};
        tbl[2]  = '{4'b0000, 16'd0,    3'd1, 16'h0000, 4'b0100, 16'd0};
        tbl[3]  = '{4'b0000, 16'd0,    3'd1, 16'h0000, 4'b0100, 16'd0};
        tbl[4]  = '{4'b0000, 16'd0,    3'd2, 16'h4000, 4'b1000, 16'd0};
        tbl[5]  = '{4'b0010, 16'd1000, 3'd2, 16'h4000, 4'b1000, 16'd62};
        tbl[6]  = '{4'b0010, 16'hFC18, 3'd2, 16'h4000, 4'b1000, 16'd120};
        tbl[7]  = '{4'b0000, 16'd5000, 3'd2, 16'h4000, 4'b1000, 16'd120};
        tbl[8]  = '{4'b0010, 16'h8000, 3'd2, 16'h4000, 4'b1000, 16'd2160};
        tbl[9]  = '{4'b0001, 16'd0,    3'd2, 16'h4000, 4'b1000, 16'd2160};
        tbl[10] = '{4'b0100, 16'd0,    3'd4, 16'h0000, 4'b0000, 16'd2160};
        tbl[11] = '{4'b0111, 16'd0,    3'd4, 16'h0000, 4'b0000, 16'd2160};
        tbl[12] = '{4'b0000, 16'd0,    3'd2, 16'h4000, 4'b1000, 16'd2160};
        tbl[13] = '{4'b0011, 16'd0,    3'd5, 16'h0000, 4'b0001, 16'd2160};
        tbl[14] = '{4'b0100, 16'd0,    3'd5, 16'h0000, 4'b0001, 16'd2160};
        tbl[15] = '{4'b1000, 16'd0,    3'd1, 16'h0000, 4'b0100, 16'd2160};
        tbl[16] = '{4'b0000, 16'd0,    3'd1, 16'h0000, 4'b0100, 16'd0};
        tbl[17] = '{4'b0000, 16'd0,    3'd1, 16'h0000, 4'b0100, 16'd0};
        tbl[18] = '{4'b0000, 16'd0,    3'd1, 16'h0000, 4'b0100, 16'd0};
        tbl[19] = '{4'b0000, 16'd0,    3'd2, 16'h4000, 4'b1000, 16'd0};

        rstn              = 1'b0;
        bus.i_mu_init     = 16'h4000;
        bus.i_mu_floor    = 16'h0400;
        bus.i_conv_thresh = 16'd10;
        drive(4'b1011, 16'h1234);
        repeat (2) cyc();
        chk_out("reset", 3'd0, 16'h0000, 4'b0000);
        chk("reset.avg", 32'(bus.o_err_avg), 32'd0);
        rstn = 1'b1;
        drive(4'b0000, 16'd0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk_out("idle", 3'd0, 16'h0000, 4'b0000);
        end

        // Start/clear, averaging, freeze, fault and restart vectors
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].ctl, tbl[i].err);
            cyc();
            chk_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].step, tbl[i].flg);
            chk($sformatf("vec%0d.avg", i), 32'(bus.o_err_avg), 32'(tbl[i].avg));
        end

        // Step decay 0x4000 -> 0x0400 floor with a large error (no convergence)
        m_avg = 16'd0;
        for (int k = 1; k <= 266; k++) begin
            drive(4'b0010, 16'd1000);
            cyc();
            m_avg = avg_upd(m_avg, 16'd1000);
            chk($sformatf("decay.step@%0d", k), 32'(bus.o_step_size),
                32'(exp_step(16'h4000, 16'h0400, k)));
        end
        chk_out("decay.end", 3'd2, 16'h0400, 4'b1000);
        chk("decay.avg", 32'(bus.o_err_avg), 32'(m_avg));

        // Convergence with zero error
        restart("conv", 16'h4000);
        for (int k = 1; k <= 31; k++) begin
            drive(4'b0010, 16'd0);
            cyc();
        end
        chk_out("conv.pre", 3'd2, 16'h4000, 4'b1000);
        cyc();
        chk_out("conv.track", 3'd3, 16'h0400, 4'b1010);
        drive(4'b0100, 16'd0);
        cyc();
        chk_out("track.freeze", 3'd4, 16'h0000, 4'b0010);
        drive(4'b0000, 16'd0);
        cyc();
        chk_out("track.resume", 3'd3, 16'h0400, 4'b1010);
        drive(4'b0001, 16'd0);
        cyc();
        chk_out("track.ovr_novalid", 3'd3, 16'h0400, 4'b1010);
        drive(4'b0011, 16'd0);
        cyc();
        chk_out("track.fault", 3'd5, 16'h0000, 4'b0001);

        // Freeze mid-TRAIN at step 0x1000; decay count must continue afterwards
        restart("frz", 16'h4000);
        for (int k = 1; k <= 158; k++) begin
            drive(4'b0010, 16'd1000);
            cyc();
            m_avg = avg_upd(m_avg, 16'd1000);
        end
        chk_out("frz.pre", 3'd2, 16'h1000, 4'b1000);
        drive(4'b0100, 16'd1000);
        cyc();
        chk_out("frz.enter", 3'd4, 16'h0000, 4'b0000);
        for (int k = 0; k < 19; k++) begin
            drive(4'b0110, 16'd30000);
            cyc();
            chk_out("frz.hold", 3'd4, 16'h0000, 4'b0000);
        end
        chk("frz.avg", 32'(bus.o_err_avg), 32'(m_avg));
        drive(4'b0000, 16'd0);
        cyc();
        chk_out("frz.exit", 3'd2, 16'h1000, 4'b1000);
        for (int k = 1; k <= 33; k++) begin
            drive(4'b0010, 16'd1000);
            cyc();
            m_avg = avg_upd(m_avg, 16'd1000);
        end
        chk("frz.step33", 32'(bus.o_step_size), 32'h1000);
        cyc();
        m_avg = avg_upd(m_avg, 16'd1000);
        chk("frz.step34", 32'(bus.o_step_size), 32'h0800);
        chk("frz.avg_end", 32'(bus.o_err_avg), 32'(m_avg));

        // mu_init below floor: floor from entry, no decay below it
        bus.i_mu_init = 16'h0300;
        restart("lowmu", 16'h0400);
        for (int k = 1; k <= 64; k++) begin
            drive(4'b0010, 16'd1000);
            cyc();
        end
        chk_out("lowmu.end", 3'd2, 16'h0400, 4'b1000);

        drive(4'b0000, 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/lms_adapt_ctrl.md
Name: lms_adapt_ctrl

Overview:
- Sequences adaptation of the LMS adaptive filter. Drives step size, adaptation enable and weight-clear.
- Schedules step size from a coarse training value down to a tracking floor.
- Detects convergence from a leaky average of |error|. Latches a fault on filter overflow.
- Sits beside the filter: consumes its error/overflow outputs, feeds its step_size input.

Parameters:
- WIDTH, 16, data/step width (matches filter WIDTH).
- DECAY_PERIOD, 64, valid samples between step-size halvings in TRAIN.
- AVG_SHIFT, 4, leaky-average coefficient 2^-AVG_SHIFT.
- CONV_HOLD, 32, consecutive valid samples with avg below threshold to declare convergence.
- CLR_CYCLES, 4, cycles o_weights_clr is held in CLEAR.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- i_start  in  1  pulse; (re)start training from any state except CLEAR
- i_freeze  in  1  level; suspend adaptation
- i_valid  in  1  sample strobe; error/ovr qualified by it
- i_error  in  WIDTH  signed filter error
- i_ovr  in  1  filter overflow flag
- i_mu_init  in  WIDTH  unsigned initial step size
- i_mu_floor  in  WIDTH  unsigned tracking step size
- i_conv_thresh  in  WIDTH  unsigned convergence threshold on avg |error|
- o_step_size  out  WIDTH  step size to filter
- o_adapt_en  out  1  high in TRAIN/TRACK
- o_weights_clr  out  1  weight clear request
- o_state  out  3  IDLE=0 CLEAR=1 TRAIN=2 TRACK=3 FREEZE=4 FAULT=5
- o_converged  out  1  sticky until restart
- o_fault  out  1  high in FAULT
- o_err_avg  out  WIDTH  leaky average of |error|

Behaviour:
- Reset (synchronous, active-low):
  - state=IDLE; all outputs 0; counters and average 0.
- Registered outputs: any event in cycle n is visible at n+1.
- |error| saturates: the most-negative input maps to 2^(WIDTH-1)-1.
- Average, updated on i_valid in TRAIN/TRACK only:
  - avg += (|e| - avg) >>> AVG_SHIFT, using a WIDTH+1 signed intermediate.
  - Result is never negative.
- Transition priority, highest first: i_ovr&i_valid while adapting -> FAULT; i_start; i_freeze; local transitions.
- IDLE: step=0, adapt_en=0. i_start -> CLEAR.
- CLEAR:
  - weights_clr=1 for exactly CLR_CYCLES cycles.
  - avg, decay count, hold count and converged are zeroed.
  - Then -> TRAIN with step=i_mu_init. i_start here is ignored.
- TRAIN:
  - Every DECAY_PERIOD valid samples, step = max(step>>1, i_mu_floor).
  - Hold counter increments on valid samples with avg<i_conv_thresh; resets to 0 when avg>=thresh.
  - Hold count reaching CONV_HOLD -> TRACK: converged=1, step=i_mu_floor.
  - If i_mu_init<=i_mu_floor, step=i_mu_floor from entry; no decay occurs.
- TRACK: step=i_mu_floor, adapt_en=1. Stays until i_start, i_freeze or fault.
- FREEZE:
  - Entered from TRAIN/TRACK on i_freeze=1. Return state is remembered.
  - step=0, adapt_en=0. Counters and avg hold their values.
  - i_freeze=0 -> return state; step restored to its pre-freeze value.
  - i_start in FREEZE -> CLEAR.
- FAULT:
  - fault=1, adapt_en=0, step=0, converged cleared.
  - Only i_start exits (-> CLEAR, which clears the weights). i_freeze is ignored.
- i_start in TRAIN/TRACK -> CLEAR (restart).
- i_valid=0 cycles: no counter or average update. i_ovr is ignored when i_valid=0, and in IDLE/CLEAR/FREEZE.

Optional Feature:
- Macro LMS_ADAPT_CTRL_RETRAIN_EN.
- When defined:
  - In TRACK, if avg >= 2*i_conv_thresh (saturating compare) for CONV_HOLD consecutive valid samples -> TRAIN.
  - The transition sets step=i_mu_init>>1 (clamped to floor) and clears converged. Weights are not cleared.
- When undefined: TRACK never leaves on error level; hold logic in TRACK is absent.

Test Plan:
- Reset then idle: rstn=0 for 2 cycles, then i_start unasserted 10 cycles -> o_state=0, o_step_size=0, all flags 0.
- Start and clear: i_start pulse with CLR_CYCLES=4 -> weights_clr high exactly 4 cycles, then o_state=2, o_step_size=i_mu_init (0x4000).
- Decay: mu_init=0x4000, floor=0x0400, DECAY_PERIOD=64, error=1000, thresh=10 -> step 0x2000 after 64 valids, 0x1000 after 128, 0x0800 after 192, then 0x0400 held; no TRACK.
- Convergence: error=0 constant, thresh=10 -> TRACK after CONV_HOLD=32 valids; converged=1; step=floor.
- Freeze/resume: i_freeze for 20 cycles mid-TRAIN at step 0x1000 -> step=0 and adapt_en=0 throughout; afterwards step=0x1000 and the decay count is continued, not restarted.
- Fault: i_ovr=1 with i_valid=1 in TRACK -> FAULT next cycle; i_ovr with i_valid=0 -> no effect; i_start -> CLEAR -> TRAIN; error=-32768 -> avg input saturates to 32767.
